button_event_decoder: RTL and testbench

Gesture decoder placed directly downstream of the button debouncer. It consumes the clean, synchronised button level and classifies presses into one-cycle event pulses: press, release, click (single short press), long press and double click. With the optional auto-repeat feature, it also emits periodic repeat pulses while the button is held. It feeds the UI/control logic, which only ever sees single-cycle events.

---
 rtl/button_event_decoder.sv | 157 +++++++++++++++
 tb/tb_button_event_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Button gesture decoder: press/release/click/long/double one-cycle pulses.
// Define BTN_AUTOREPEAT_EN to enable periodic o_repeat pulses while held long.
module button_event_decoder #(
  parameter int unsigned CNT_WIDTH     = 24,
  parameter int unsigned LONG_CYCLES   = 12_000_000,
  parameter int unsigned DBL_CYCLES    = 6_000_000,
  parameter int unsigned REPEAT_CYCLES = 2_400_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_long,
  output logic o_double,
  output logic o_repeat
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG,
    WAIT2,
    PRESS2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_M1 =
    CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DBL_M1 =
    CNT_WIDTH'(DBL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 btn_q;
  logic                 press_q;
  logic                 rel_q;
  logic                 click_q;
  logic                 long_q;
  logic                 dbl_q;
  logic                 rise;
  logic                 fall;

  assign rise = i_button & ~btn_q;
  assign fall = ~i_button & btn_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REP_M1 =
    CNT_WIDTH'(REPEAT_CYCLES - 1);
  logic rep_q;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      click_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      btn_q   <= i_button;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      click_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_q   <= 1'b0;
`endif
      // Input edges are tested before timer expiry so they win ties.
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise) begin
            state_q <= PRESS1;
            press_q <= 1'b1;
          end
        end
        PRESS1: begin
          if (fall) begin
            state_q <= WAIT2;
            cnt_q   <= '0;
            rel_q   <= 1'b1;
          end else if (cnt_q == LONG_M1) begin
            state_q <= LONG;
            cnt_q   <= '0;
            long_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        LONG: begin
          if (fall) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rel_q   <= 1'b1;
          end else begin
`ifdef BTN_AUTOREPEAT_EN
            if (cnt_q == REP_M1) begin
              cnt_q <= '0;
              rep_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
`else
            cnt_q <= cnt_q;
`endif
          end
        end
        WAIT2: begin
          if (rise) begin
            state_q <= PRESS2;
            cnt_q   <= '0;
            press_q <= 1'b1;
            dbl_q   <= 1'b1;
          end else if (cnt_q == DBL_M1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            click_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        PRESS2: begin
          if (fall) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rel_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_press   = press_q;
  assign o_release = rel_q;
  assign o_click   = click_q;
  assign o_long    = long_q;
  assign o_double  = dbl_q;
`ifdef BTN_AUTOREPEAT_EN
  assign o_repeat  = rep_q;
`else
  assign o_repeat  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed vector bench for button_event_decoder.
// Output vector order: {press, release, click, long, double, repeat}.
module tb_button_event_decoder;

  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] P  = 6'b100000;
  localparam logic [5:0] R  = 6'b010000;
  localparam logic [5:0] C  = 6'b001000;
  localparam logic [5:0] L  = 6'b000100;
  localparam logic [5:0] D  = 6'b000010;
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [5:0] RP = 6'b000001;
`else
  localparam logic [5:0] RP = 6'b000000;
`endif

  typedef struct {
    logic       btn;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic o_press, o_release, o_click;
  logic o_long, o_double, o_repeat;
  logic [5:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vq[$];

  button_event_decoder #(
    .CNT_WIDTH    (4),
    .LONG_CYCLES  (8),
    .DBL_CYCLES   (5),
    .REPEAT_CYCLES(3)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_button (btn),
    .o_press  (o_press),
    .o_release(o_release),
    .o_click  (o_click),
    .o_long   (o_long),
    .o_double (o_double),
    .o_repeat (o_repeat)
  );

  always #5 clk = ~clk;

  assign obs = {o_press, o_release, o_click,
                o_long, o_double, o_repeat};

  task automatic chk(input string nm, input logic [5:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, obs, exp);
    end
  endtask

  task automatic add(input logic b, input logic [5:0] e);
    vec_t v;
    v.btn = b;
    v.exp = e;
    vq.push_back(v);
  endtask

  task automatic step(input logic b);
    @(negedge clk);
    btn = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Short press: 3 edges high, click 5 edges after release
    add(0, Z); add(1, P); add(1, Z); add(1, Z);
    add(0, R);
    for (int i = 1; i < 5; i++) add(0, Z);
    add(0, C); add(0, Z);
    // Long press held 20 edges
    add(1, P);
    for (int e = 1; e < 20; e++)
      add(1, (e == 8) ? L :
             ((e == 11 || e == 14 || e == 17) ? RP : Z));
    add(0, R);
    for (int i = 0; i < 7; i++) add(0, Z);
    // Double click
    add(1, P); add(1, Z); add(0, R); add(0, Z);
    add(1, P | D); add(1, Z); add(0, R);
    for (int i = 0; i < 7; i++) add(0, Z);
    // Second rise exactly at window expiry
    add(1, P); add(0, R);
    for (int i = 1; i < 5; i++) add(0, Z);
    add(1, P | D); add(0, R);
    for (int i = 0; i < 7; i++) add(0, Z);
    // Fall exactly at long expiry
    add(1, P);
    for (int e = 1; e < 8; e++) add(1, Z);
    add(0, R);
    for (int i = 1; i < 5; i++) add(0, Z);
    add(0, C); add(0, Z); add(0, Z);

    // Reset state
    #2;
    chk("reset_held", Z);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held_clk", Z);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_release", Z);

    foreach (vq[i]) begin
      step(vq[i].btn);
      chk($sformatf("vec%0d", i), vq[i].exp);
    end

    // Reset two cycles into WAIT2
    step(1); chk("mid_press", P);
    step(0); chk("mid_release", R);
    step(0); chk("mid_wait1", Z);
    step(0); chk("mid_wait2", Z);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_async", Z);
    @(posedge clk);
    #1;
    chk("mid_rst_clk", Z);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_release", Z);
    for (int i = 0; i < 10; i++) begin
      step(0);
      chk($sformatf("mid_noclick%0d", i), Z);
    end

    // Button held through reset deassertion
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("held_first_cycle", Z);
    @(posedge clk);
    #1;
    chk("held_press", P);
    for (int e = 1; e < 8; e++) begin
      step(1);
      chk($sformatf("held_wait%0d", e), Z);
    end
    step(1); chk("held_long", L);
    step(0); chk("held_release", R);
    for (int i = 0; i < 7; i++) begin
      step(0);
      chk($sformatf("held_idle%0d", i), Z);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
